pc_unit_rv: RTL and testbench
=============================

Name: pc_unit_rv

Overview:
Registered program-counter unit for the RV multicycle core. It is the successor to the combinational next-PC logic: it holds the architectural PC and issues it to fetch with a valid/ready handshake. It then waits for execute to resolve the control flow of that instruction and computes the next PC from SEQ/JAL/JALR/B sources. It adds parametrised width and vectors, JALR bit-0 clearing, and misaligned-target trapping.

Parameters:
XLEN, 32, PC and register datapath width (>= 21)
RESET_VECTOR, 0, PC loaded on reset
TRAP_VECTOR, 32'h0000_0100, PC loaded after a misaligned-target trap

Ports:
iwClock  input  1  clock, rising edge
iwReset  input  1  asynchronous, active-high reset
iwPcSrc  input  2  next-PC source: SEQ / JAL / JALR / B
iwRegister  input  XLEN  rs1 value for JALR
iwImmediate20  input  20  raw instr[31:12] (J-type scrambled)
iwImmediate12  input  12  B-type {imm12, imm10:5, imm4:1, imm11} layout or I-type imm for JALR
iwBranchStatus  input  1  branch condition true
iwCompressed  input  1  current instruction is 16-bit (used only with RVC_EN)
iwExecValid  input  1  execute presents resolved control info for issued PC
owExecReady  output  1  unit waiting for resolution
owPc  output  XLEN  PC offered to fetch
owPcValid  output  1  owPc valid
iwFetchReady  input  1  fetch accepts owPc
owMisaligned  output  1  one-cycle trap pulse
owBadTarget  output  XLEN  offending target, valid with owMisaligned

Behaviour:
- States: S_ISSUE, S_WAIT, S_TRAP. Reset (async) forces S_ISSUE, PC=RESET_VECTOR, owMisaligned=0, owBadTarget=0. It takes effect immediately in any state, including mid-handshake.
- S_ISSUE: owPcValid=1, owExecReady=0.
  - owPc stays stable until owPcValid&&iwFetchReady.
  - On that handshake, move to S_WAIT.
- S_WAIT: owPcValid=0, owExecReady=1. When iwExecValid=1, compute target T relative to the held PC, then:
  - SEQ, or B with iwBranchStatus=0: T=PC+4.
  - JAL: T=PC+sext({imm20[19],imm20[7:0],imm20[8],imm20[18:9],0}).
  - B taken: T=PC+sext({imm12[11],imm12[0],imm12[10:5],imm12[4:1],0}).
  - JALR: T=(iwRegister+sext(imm12)) with bit 0 cleared.
  - All adds are modulo 2^XLEN; wrap-around is silent.
  - If T[1:0]!=0: go to S_TRAP and latch owBadTarget=T. Otherwise PC<=T and go to S_ISSUE.
- S_TRAP: owMisaligned=1 for exactly one cycle, PC<=TRAP_VECTOR, then S_ISSUE. owBadTarget holds its value until the next trap or reset.
- The sequential fall-through (PC+4) is never misaligned when the PC is aligned; only JAL/JALR/B targets can trap.
- Latency: resolution to new owPcValid is 1 cycle (normal) or 2 cycles (trap).
- iwExecValid is ignored outside S_WAIT. iwFetchReady is ignored outside S_ISSUE.

Optional Feature:
RVC_EN.
- Defined: alignment check is T[0]!=0, which can never fire after JALR clearing. The SEQ step is +2 when iwCompressed=1, else +4.
- Undefined: iwCompressed is ignored, the step is always +4, and the check is T[1:0]!=0.

Decomposition:
- Shared package: PC-source encodings NEXT_PC_SRC_SEQ=0, JAL=1, JALR=2, B=3, plus state encodings.
- Sub-module pc_target_rv (combinational, parametrised by XLEN): immediate unscrambling, sign extension and target adder. pc_unit_rv owns the FSM and the registers.

Test Plan:
1. Release reset -> owPc=0x0, owPcValid=1. Handshake, then SEQ resolve -> owPc=0x4 one cycle later.
2. From PC=0x4, JAL with iwImmediate20=20'h00800 (+8) -> owPc=0xC.
3. From PC=0xC, B with iwImmediate12=12'hFFD (-4): taken -> 0x8; not taken -> 0x10.
4. JALR with iwRegister=0x1001, imm12=0x002 -> T=0x1002. Without RVC_EN: owMisaligned pulses for 1 cycle, owBadTarget=0x1002, then owPc=0x100. With RVC_EN: owPc=0x1002.
5. Hold iwFetchReady=0 for 3 cycles in S_ISSUE -> owPc and owPcValid stable; iwExecValid pulses are ignored.
6. Assert iwReset asynchronously while in S_WAIT -> owPc=RESET_VECTOR and owPcValid=1 without waiting for a clock edge; owExecReady=0.

Source files
------------

// File: rtl/pc_unit_rv_pkg.sv
// Shared definitions for the registered program-counter unit.
// Holds the next-PC source encodings driven by decode and the FSM state
// encodings used by pc_unit_rv.
package pc_unit_rv_pkg;

    // Width of the next-PC source selector and of the FSM state register
    localparam int PC_SRC_W = 2;
    localparam int STATE_W  = 2;

    // Next-PC source selector values
    localparam logic [PC_SRC_W-1:0] NEXT_PC_SRC_SEQ  = 2'd0;
    localparam logic [PC_SRC_W-1:0] NEXT_PC_SRC_JAL  = 2'd1;
    localparam logic [PC_SRC_W-1:0] NEXT_PC_SRC_JALR = 2'd2;
    localparam logic [PC_SRC_W-1:0] NEXT_PC_SRC_B    = 2'd3;

    // FSM states: offer PC to fetch, wait for execute, report a trap
    localparam logic [STATE_W-1:0] S_ISSUE = 2'd0;
    localparam logic [STATE_W-1:0] S_WAIT  = 2'd1;
    localparam logic [STATE_W-1:0] S_TRAP  = 2'd2;

    // Byte step for the sequential fall-through of an uncompressed instruction
    localparam int SEQ_STEP_FULL = 4;
    // Byte step for the sequential fall-through of a compressed instruction
    localparam int SEQ_STEP_HALF = 2;

endpackage

// File: rtl/pc_target_rv.sv
// Combinational next-PC target generator.
// Unscrambles the J-type and B-type immediates, sign-extends them and
// forms the candidate target for the selected PC source. JALR targets
// have bit 0 forced to zero. All additions wrap modulo 2^XLEN.
// Optional feature macro: RVC_EN (enables the +2 step for compressed
// instructions; otherwise the compressed flag is ignored).
module pc_target_rv
    import pc_unit_rv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0]     pc_i,
    input  logic [PC_SRC_W-1:0] pcSrc_i,
    input  logic [XLEN-1:0]     register_i,
    input  logic [19:0]         imm20_i,
    input  logic [11:0]         imm12_i,
    input  logic                branchTaken_i,
    input  logic                compressed_i,
    output logic [XLEN-1:0]     target_o
);

    logic [20:0]     jalOffset;
    logic [12:0]     branchOffset;
    logic [XLEN-1:0] jalOffsetExt;
    logic [XLEN-1:0] branchOffsetExt;
    logic [XLEN-1:0] jalrImmExt;
    logic [XLEN-1:0] seqStep;
    logic [XLEN-1:0] jalrSum;

    // J-type offset: instr[31|19:12|20|30:21] with an implicit zero LSB
    assign jalOffset = {imm20_i[19], imm20_i[7:0], imm20_i[8], imm20_i[18:9], 1'b0};

    // B-type offset: {imm12, imm11, imm10:5, imm4:1} from the packed field, zero LSB
    assign branchOffset = {imm12_i[11], imm12_i[0], imm12_i[10:5], imm12_i[4:1], 1'b0};

    // Sign-extend all offsets to the datapath width
    assign jalOffsetExt    = XLEN'($signed(jalOffset));
    assign branchOffsetExt = XLEN'($signed(branchOffset));
    assign jalrImmExt      = XLEN'($signed(imm12_i));

    // JALR base plus immediate before the LSB is cleared
    assign jalrSum = register_i + jalrImmExt;

`ifdef RVC_EN
    // Fall-through step depends on the length of the current instruction
    always_comb begin
        seqStep = XLEN'(SEQ_STEP_FULL);
        if (compressed_i) begin
            seqStep = XLEN'(SEQ_STEP_HALF);
        end
    end
`else
    logic unusedCompressed;
    assign unusedCompressed = compressed_i;

    // Without compressed support every instruction is four bytes long
    always_comb begin
        seqStep = XLEN'(SEQ_STEP_FULL);
    end
`endif

    // Select the target for the resolved control-flow source
    always_comb begin
        target_o = pc_i + seqStep;
        case (pcSrc_i)
            NEXT_PC_SRC_SEQ:  target_o = pc_i + seqStep;
            NEXT_PC_SRC_JAL:  target_o = pc_i + jalOffsetExt;
            NEXT_PC_SRC_JALR: target_o = {jalrSum[XLEN-1:1], 1'b0};
            NEXT_PC_SRC_B: begin
                if (branchTaken_i) begin
                    target_o = pc_i + branchOffsetExt;
                end else begin
                    target_o = pc_i + seqStep;
                end
            end
            default:          target_o = pc_i + seqStep;
        endcase
    end

endmodule

// File: rtl/pc_unit_rv.sv
// Registered program-counter unit for the RV multicycle core.
// Offers the architectural PC to fetch with a valid/ready handshake, then
// waits for execute to resolve the instruction's control flow and loads
// the next PC. Misaligned targets produce a one-cycle trap pulse, record
// the offending address and redirect to TRAP_VECTOR.
// Optional feature macro: RVC_EN (16-bit instructions: +2 fall-through and
// a halfword-only alignment check).
module pc_unit_rv
    import pc_unit_rv_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100)
) (
    input  logic                iwClock,
    input  logic                iwReset,
    input  logic [PC_SRC_W-1:0] iwPcSrc,
    input  logic [XLEN-1:0]     iwRegister,
    input  logic [19:0]         iwImmediate20,
    input  logic [11:0]         iwImmediate12,
    input  logic                iwBranchStatus,
    input  logic                iwCompressed,
    input  logic                iwExecValid,
    output logic                owExecReady,
    output logic [XLEN-1:0]     owPc,
    output logic                owPcValid,
    input  logic                iwFetchReady,
    output logic                owMisaligned,
    output logic [XLEN-1:0]     owBadTarget
);

    logic [STATE_W-1:0] state_q;
    logic [STATE_W-1:0] state_d;
    logic [XLEN-1:0]    pc_q;
    logic [XLEN-1:0]    pc_d;
    logic [XLEN-1:0]    badTarget_q;
    logic [XLEN-1:0]    badTarget_d;
    logic [XLEN-1:0]    target;
    logic               targetMisaligned;

    pc_target_rv #(
        .XLEN          (XLEN)
    ) uTarget (
        .pc_i          (pc_q),
        .pcSrc_i       (iwPcSrc),
        .register_i    (iwRegister),
        .imm20_i       (iwImmediate20),
        .imm12_i       (iwImmediate12),
        .branchTaken_i (iwBranchStatus),
        .compressed_i  (iwCompressed),
        .target_o      (target)
    );

`ifdef RVC_EN
    // Halfword alignment suffices when compressed instructions exist
    assign targetMisaligned = target[0];
`else
    // Word alignment is required when every instruction is four bytes
    assign targetMisaligned = |target[1:0];
`endif

    // Next-state, next-PC and trap-address selection
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        badTarget_d = badTarget_q;
        case (state_q)
            S_ISSUE: begin
                if (iwFetchReady) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (iwExecValid) begin
                    if (targetMisaligned) begin
                        state_d     = S_TRAP;
                        badTarget_d = target;
                    end else begin
                        state_d = S_ISSUE;
                        pc_d    = target;
                    end
                end
            end
            S_TRAP: begin
                state_d = S_ISSUE;
                pc_d    = TRAP_VECTOR;
            end
            default: begin
                state_d = S_ISSUE;
            end
        endcase
    end

    // State, PC and trap-address registers with asynchronous reset
    always_ff @(posedge iwClock or posedge iwReset) begin
        if (iwReset) begin
            state_q     <= S_ISSUE;
            pc_q        <= RESET_VECTOR;
            badTarget_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            badTarget_q <= badTarget_d;
        end
    end

    // Outputs are decoded straight from registers so reset shows at once
    assign owPcValid    = (state_q == S_ISSUE);
    assign owExecReady  = (state_q == S_WAIT);
    assign owMisaligned = (state_q == S_TRAP);
    assign owPc         = pc_q;
    assign owBadTarget  = badTarget_q;

endmodule

// File: tb/tb_pc_unit_rv.sv
// Self-checking bench for pc_unit_rv. The stimulus process pushes the
// PC it expects to be handed to fetch, and the address it expects a trap
// to report, into queues; a monitor pops and compares them whenever the
// DUT completes a fetch handshake or raises its trap pulse.
// Optional feature macro: RVC_EN (expected values follow the DUT build).
module tb_pc_unit_rv;

    logic        iwClock = 1'b0;
    logic        iwReset;
    logic [1:0]  iwPcSrc;
    logic [31:0] iwRegister;
    logic [19:0] iwImmediate20;
    logic [11:0] iwImmediate12;
    logic        iwBranchStatus;
    logic        iwCompressed;
    logic        iwExecValid;
    logic        owExecReady;
    logic [31:0] owPc;
    logic        owPcValid;
    logic        iwFetchReady;
    logic        owMisaligned;
    logic [31:0] owBadTarget;

    int total = 0;
    int bad   = 0;

    logic [31:0] expPcQ[$];
    logic [31:0] expBadQ[$];

    localparam logic [1:0] SRC_SEQ  = 2'd0;
    localparam logic [1:0] SRC_JAL  = 2'd1;
    localparam logic [1:0] SRC_JALR = 2'd2;
    localparam logic [1:0] SRC_B    = 2'd3;

    pc_unit_rv #(
        .XLEN           (32),
        .RESET_VECTOR   (32'h0000_0000),
        .TRAP_VECTOR    (32'h0000_0100)
    ) dut (
        .iwClock        (iwClock),
        .iwReset        (iwReset),
        .iwPcSrc        (iwPcSrc),
        .iwRegister     (iwRegister),
        .iwImmediate20  (iwImmediate20),
        .iwImmediate12  (iwImmediate12),
        .iwBranchStatus (iwBranchStatus),
        .iwCompressed   (iwCompressed),
        .iwExecValid    (iwExecValid),
        .owExecReady    (owExecReady),
        .owPc           (owPc),
        .owPcValid      (owPcValid),
        .iwFetchReady   (iwFetchReady),
        .owMisaligned   (owMisaligned),
        .owBadTarget    (owBadTarget)
    );

    // 10 ns clock
    always #5 iwClock = ~iwClock;

    // Hard time limit so the run always ends
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] time limit reached");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    // Monitor: compare on fetch handshakes and trap pulses
    always @(negedge iwClock) begin
        if (!iwReset) begin
            if (owPcValid && iwFetchReady) begin
                if (expPcQ.size() == 0) begin
                    checkOutput("unexpected_fetch", owPc, 32'hDEAD_BEEF);
                end else begin
                    checkOutput("fetch_pc", owPc, expPcQ.pop_front());
                end
            end
            if (owMisaligned) begin
                if (expBadQ.size() == 0) begin
                    checkOutput("unexpected_trap", owBadTarget, 32'hDEAD_BEEF);
                end else begin
                    checkOutput("bad_target", owBadTarget, expBadQ.pop_front());
                end
            end
        end
    end

    task automatic handshake();
        iwFetchReady = 1'b1;
        @(posedge iwClock);
        #1;
        iwFetchReady = 1'b0;
    endtask

    // Hand the current PC to fetch, then resolve it with the given inputs
    task automatic applyStimulus(input logic [1:0] src, input logic [31:0] rs1,
                                 input logic [19:0] imm20, input logic [11:0] imm12,
                                 input logic taken, input logic comp,
                                 input logic [31:0] expNext, input logic expTrap,
                                 input logic [31:0] expBadTarget);
        handshake();
        checkOutput("wait_exec_ready", {31'b0, owExecReady}, 32'd1);
        checkOutput("wait_pc_valid", {31'b0, owPcValid}, 32'd0);
        iwPcSrc        = src;
        iwRegister     = rs1;
        iwImmediate20  = imm20;
        iwImmediate12  = imm12;
        iwBranchStatus = taken;
        iwCompressed   = comp;
        iwExecValid    = 1'b1;
        if (expTrap) begin
            expBadQ.push_back(expBadTarget);
        end
        expPcQ.push_back(expNext);
        @(posedge iwClock);
        #1;
        iwExecValid = 1'b0;
        if (expTrap) begin
            checkOutput("trap_pulse", {31'b0, owMisaligned}, 32'd1);
            checkOutput("trap_pc_valid", {31'b0, owPcValid}, 32'd0);
            @(posedge iwClock);
            #1;
            checkOutput("trap_pulse_end", {31'b0, owMisaligned}, 32'd0);
        end else begin
            checkOutput("no_trap", {31'b0, owMisaligned}, 32'd0);
        end
        checkOutput("next_pc_valid", {31'b0, owPcValid}, 32'd1);
        checkOutput("next_pc", owPc, expNext);
    endtask

    initial begin
        iwReset        = 1'b1;
        iwPcSrc        = SRC_SEQ;
        iwRegister     = '0;
        iwImmediate20  = '0;
        iwImmediate12  = '0;
        iwBranchStatus = 1'b0;
        iwCompressed   = 1'b0;
        iwExecValid    = 1'b0;
        iwFetchReady   = 1'b0;
        #3;
        checkOutput("reset_pc", owPc, 32'h0);
        checkOutput("reset_valid", {31'b0, owPcValid}, 32'd1);
        checkOutput("reset_misaligned", {31'b0, owMisaligned}, 32'd0);
        checkOutput("reset_bad_target", owBadTarget, 32'h0);
        @(posedge iwClock);
        #1;
        iwReset = 1'b0;
        expPcQ.push_back(32'h0);

        // Sequential, JAL and both branch outcomes
        applyStimulus(SRC_SEQ, 32'h0, 20'h00000, 12'h000, 1'b0, 1'b0, 32'h0000_0004, 1'b0, 32'h0);
        applyStimulus(SRC_JAL, 32'h0, 20'h00800, 12'h000, 1'b0, 1'b0, 32'h0000_000C, 1'b0, 32'h0);
        applyStimulus(SRC_B,   32'h0, 20'h00000, 12'hFFD, 1'b1, 1'b0, 32'h0000_0008, 1'b0, 32'h0);
        applyStimulus(SRC_SEQ, 32'h0, 20'h00000, 12'h000, 1'b0, 1'b0, 32'h0000_000C, 1'b0, 32'h0);
        applyStimulus(SRC_B,   32'h0, 20'h00000, 12'hFFD, 1'b0, 1'b0, 32'h0000_0010, 1'b0, 32'h0);

`ifdef RVC_EN
        applyStimulus(SRC_JALR, 32'h0000_1001, 20'h0, 12'h002, 1'b0, 1'b0, 32'h0000_1002, 1'b0, 32'h0);
`else
        applyStimulus(SRC_JALR, 32'h0000_1001, 20'h0, 12'h002, 1'b0, 1'b0, 32'h0000_0100, 1'b1, 32'h0000_1002);
`endif
        // JALR with wrap-around past 2^32
        applyStimulus(SRC_JALR, 32'hFFFF_FFFC, 20'h0, 12'h008, 1'b0, 1'b0, 32'h0000_0004, 1'b0, 32'h0);
`ifdef RVC_EN
        applyStimulus(SRC_SEQ, 32'h0, 20'h0, 12'h000, 1'b0, 1'b1, 32'h0000_0006, 1'b0, 32'h0);
        applyStimulus(SRC_JAL, 32'h0, 20'h00200, 12'h000, 1'b0, 1'b0, 32'h0000_0008, 1'b0, 32'h0);
`else
        applyStimulus(SRC_SEQ, 32'h0, 20'h0, 12'h000, 1'b0, 1'b1, 32'h0000_0008, 1'b0, 32'h0);
        applyStimulus(SRC_JAL, 32'h0, 20'h00200, 12'h000, 1'b0, 1'b0, 32'h0000_0100, 1'b1, 32'h0000_000A);
`endif
        // JALR clears bit 0 of an odd sum
        applyStimulus(SRC_JALR, 32'h0000_0200, 20'h0, 12'h005, 1'b0, 1'b0, 32'h0000_0204, 1'b0, 32'h0);
`ifdef RVC_EN
        applyStimulus(SRC_B, 32'h0, 20'h0, 12'h002, 1'b1, 1'b0, 32'h0000_0206, 1'b0, 32'h0);
`else
        applyStimulus(SRC_B, 32'h0, 20'h0, 12'h002, 1'b1, 1'b0, 32'h0000_0100, 1'b1, 32'h0000_0206);
`endif
        applyStimulus(SRC_JALR, 32'h0000_0040, 20'h0, 12'h000, 1'b0, 1'b0, 32'h0000_0040, 1'b0, 32'h0);

        // Fetch stall with stray execute pulses
        for (int i = 0; i < 3; i++) begin
            iwPcSrc       = SRC_JAL;
            iwImmediate20 = 20'h00800;
            iwExecValid   = 1'b1;
            @(posedge iwClock);
            #1;
            checkOutput("stall_pc", owPc, 32'h0000_0040);
            checkOutput("stall_valid", {31'b0, owPcValid}, 32'd1);
            checkOutput("stall_exec_ready", {31'b0, owExecReady}, 32'd0);
        end
        iwExecValid = 1'b0;
        applyStimulus(SRC_SEQ, 32'h0, 20'h0, 12'h000, 1'b0, 1'b0, 32'h0000_0044, 1'b0, 32'h0);

        // Asynchronous reset while waiting for execute
        handshake();
        checkOutput("pre_reset_exec_ready", {31'b0, owExecReady}, 32'd1);
        #2;
        iwReset = 1'b1;
        #1;
        checkOutput("async_reset_pc", owPc, 32'h0);
        checkOutput("async_reset_valid", {31'b0, owPcValid}, 32'd1);
        checkOutput("async_reset_exec_ready", {31'b0, owExecReady}, 32'd0);
        @(posedge iwClock);
        #1;
        iwReset = 1'b0;
        expPcQ.push_back(32'h0);
        applyStimulus(SRC_SEQ, 32'h0, 20'h0, 12'h000, 1'b0, 1'b0, 32'h0000_0004, 1'b0, 32'h0);
        handshake();

        checkOutput("pc_queue_drained", expPcQ.size(), 32'd0);
        checkOutput("trap_queue_drained", expBadQ.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
